// File: rtl/serial_adder.sv
// serial_adder
//
// Bit-serial adder/subtractor. A single full-adder cell and a carry flip-flop
// walk two WIDTH-bit operands LSB-first, one bit per clock. Subtraction is done
// as a + ~b + ~cin, so the same cell serves both modes.
//
// Ports
//   clk       rising-edge system clock
//   rst       synchronous, active-high reset; aborts any operation in flight
//   start     request, only looked at while busy is low
//   sub       0: a + b + cin    1: a - b - cin
//   a, b      operands, captured when start is accepted
//   cin       carry-in (add) or borrow-in (sub), captured with the operands
//   sum       result, held from done until the next completed operation
//   cout      carry-out; in subtract mode 1 means no borrow
//   overflow  signed overflow (carry into MSB xor carry out of MSB)
//   busy      high from the edge after start is accepted until done drops
//   done      one-cycle pulse when sum/cout/overflow are updated
//
// One operation occupies WIDTH+2 cycles: one IDLE cycle to accept start,
// WIDTH RUN cycles (one per bit), and one DONE cycle.

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic load;
    logic step;

    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             carry;
    logic [CNT_W-1:0] bit_cnt;

    // Holds the first WIDTH-1 result bits; the last bit is joined on the fly
    // when the final sum is registered, so no bit of this register is wasted.
    logic [WIDTH-2:0] partial;

    logic             bit_sum;
    logic             bit_carry;
    logic [WIDTH-1:0] result_now;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and the handshake outputs. busy/done depend only on the
    // state register, so there is no combinational path from inputs to outputs.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        step       = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (bit_cnt == LAST_BIT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The full-adder cell working on the current LSBs.
    assign bit_sum    = sh_a[0] ^ sh_b[0] ^ carry;
    assign bit_carry  = (sh_a[0] & sh_b[0]) | (sh_a[0] & carry) | (sh_b[0] & carry);
    assign result_now = {bit_sum, partial};

    // Datapath. On load, B and the carry are pre-inverted in subtract mode so
    // the cell always adds. During the last bit the carry register still holds
    // the carry into the MSB, so overflow is taken directly as carry ^ bit_carry
    // at the same edge that registers the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_a     <= '0;
            sh_b     <= '0;
            carry    <= 1'b0;
            bit_cnt  <= '0;
            partial  <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (load) begin
            sh_a    <= a;
            sh_b    <= b ^ {WIDTH{sub}};
            carry   <= cin ^ sub;
            bit_cnt <= '0;
        end else if (step) begin
            sh_a    <= sh_a >> 1;
            sh_b    <= sh_b >> 1;
            carry   <= bit_carry;
            partial <= result_now[WIDTH-1:1];
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_BIT) begin
                sum      <= result_now;
                cout     <= bit_carry;
                overflow <= carry ^ bit_carry;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//
// Drives a WIDTH=8 and a WIDTH=4 serial_adder. Stimulus tasks push the expected
// result of every accepted operation into a per-instance queue; a monitor on the
// falling edge checks busy, done, sum, cout and overflow of both instances every
// cycle against those queues. Expected results come from plain integer
// arithmetic on the operands.

module tb_serial_adder;

    localparam int W8 = 8;
    localparam int W4 = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       start8 = 1'b0;
    logic       sub8 = 1'b0;
    logic       cin8 = 1'b0;
    logic [7:0] a8 = '0;
    logic [7:0] b8 = '0;
    logic [7:0] sum8;
    logic       cout8, ovf8, busy8, done8;

    logic       start4 = 1'b0;
    logic       sub4 = 1'b0;
    logic       cin4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic [3:0] sum4;
    logic       cout4, ovf4, busy4, done4;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } entry_t;

    entry_t q8[$];
    entry_t q4[$];
    entry_t held8 = '{sum: 0, cout: 0, ovf: 0, acc: 0};
    entry_t held4 = '{sum: 0, cout: 0, ovf: 0, acc: 0};

    int   cyc = 0;
    logic rst_q = 1'b0;
    logic armed = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .sub(sub8), .a(a8), .b(b8), .cin(cin8),
        .sum(sum8), .cout(cout8), .overflow(ovf8), .busy(busy8), .done(done8)
    );

    serial_adder #(.WIDTH(W4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sub(sub4), .a(a4), .b(b4), .cin(cin4),
        .sum(sum4), .cout(cout4), .overflow(ovf4), .busy(busy4), .done(done4)
    );

    // Cycle counter and a record of whether the last edge saw reset; the
    // monitor uses these to know when outputs must be cleared and when a
    // queued result is due.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
        if (rst) begin
            armed <= 1'b1;
        end
    end

    // Reference model: the arithmetic result of one operation.
    function automatic entry_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                     input logic cin, input logic sub);
        entry_t e;
        longint full, half, mask, ua, ub, uc, sa, sb, r, sr;
        full = longint'(1) << w;
        half = longint'(1) << (w - 1);
        mask = full - 1;
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        uc   = longint'(cin);
        sa   = (ua >= half) ? ua - full : ua;
        sb   = (ub >= half) ? ub - full : ub;
        if (!sub) begin
            r      = ua + ub + uc;
            sr     = sa + sb + uc;
            e.cout = (r >= full);
        end else begin
            r      = ua - ub - uc;
            sr     = sa - sb - uc;
            e.cout = (ua >= ub + uc);
        end
        e.sum = 32'(r & mask);
        e.ovf = (sr >= half) || (sr < -half);
        e.acc = 0;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // One cycle of checking for one instance.
    task automatic monitorUnit(input int w);
        logic [31:0] act_sum;
        logic        act_cout, act_ovf, act_busy, act_done;
        logic        exp_done;
        entry_t      head;
        entry_t      h;
        bit          have;
        string       tag;
        tag = $sformatf("w%0d", w);
        if (w == W8) begin
            act_sum = {24'd0, sum8}; act_cout = cout8; act_ovf = ovf8;
            act_busy = busy8; act_done = done8;
        end else begin
            act_sum = {28'd0, sum4}; act_cout = cout4; act_ovf = ovf4;
            act_busy = busy4; act_done = done4;
        end
        if (rst_q) begin
            if (w == W8) begin
                q8.delete();
                held8 = '{sum: 0, cout: 0, ovf: 0, acc: 0};
            end else begin
                q4.delete();
                held4 = '{sum: 0, cout: 0, ovf: 0, acc: 0};
            end
        end
        have = (w == W8) ? (q8.size() > 0) : (q4.size() > 0);
        head = '{sum: 0, cout: 0, ovf: 0, acc: 0};
        if (have) begin
            if (w == W8) head = q8[0];
            else         head = q4[0];
        end
        exp_done = have && (cyc == head.acc + w + 1 - 1) && (cyc == head.acc + w);
        checkOutput({tag, " busy"}, 32'(act_busy), 32'(have));
        checkOutput({tag, " done"}, 32'(act_done), 32'(exp_done));
        if (exp_done) begin
            if (w == W8) begin
                void'(q8.pop_front());
                held8 = head;
            end else begin
                void'(q4.pop_front());
                held4 = head;
            end
        end
        h = (w == W8) ? held8 : held4;
        checkOutput({tag, " sum"}, act_sum, h.sum);
        checkOutput({tag, " cout"}, 32'(act_cout), 32'(h.cout));
        checkOutput({tag, " overflow"}, 32'(act_ovf), 32'(h.ovf));
    endtask

    // Monitor: checks both instances on every falling edge once reset has been seen.
    always @(negedge clk) begin
        if (armed) begin
            monitorUnit(W8);
            monitorUnit(W4);
        end
    end

    // Waits (bounded) until the instance is idle; called just after a rising edge.
    task automatic waitIdle(input int w, output bit ok);
        int guard = 0;
        while (((w == W8) ? busy8 : busy4) !== 1'b0 && guard < 40) begin
            @(posedge clk);
            #1;
            guard++;
        end
        ok = (guard < 40);
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL w%0d idle wait at cycle %0d: got busy, expected idle within 40 cycles", w, cyc);
        end
    endtask

    // Issues one operation, records its accept cycle, then scrambles the
    // operands to show they are no longer looked at.
    task automatic applyStimulus(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic cin, input logic sub);
        bit     ok;
        entry_t e;
        waitIdle(w, ok);
        if (!ok) return;
        e = model(w, a, b, cin, sub);
        if (w == W8) begin
            a8 = a; b8 = b; cin8 = cin; sub8 = sub; start8 = 1'b1;
        end else begin
            a4 = a[3:0]; b4 = b[3:0]; cin4 = cin; sub4 = sub; start4 = 1'b1;
        end
        @(posedge clk);
        #1;
        e.acc = cyc;
        if (w == W8) begin
            q8.push_back(e);
            start8 = 1'b0;
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
        end else begin
            q4.push_back(e);
            start4 = 1'b0;
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); sub4 = 1'($urandom);
        end
    endtask

    // start held high with operands changing every cycle: only the operands
    // present on every (WIDTH+2)-th edge are accepted.
    task automatic holdStart(input int cycles);
        bit     ok;
        entry_t e;
        waitIdle(W8, ok);
        if (!ok) return;
        e = '{sum: 0, cout: 0, ovf: 0, acc: 0};
        for (int t = 0; t < cycles; t++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom); sub8 = 1'($urandom);
            start8 = 1'b1;
            if (t % (W8 + 2) == 0) e = model(W8, a8, b8, cin8, sub8);
            @(posedge clk);
            #1;
            if (t % (W8 + 2) == 0) begin
                e.acc = cyc;
                q8.push_back(e);
            end
        end
        start8 = 1'b0;
    endtask

    // Main stimulus sequence.
    initial begin
        bit ok;
        int guard;

        // Reset while idle, then keep reset high with start requested.
        repeat (2) begin @(posedge clk); #1; end
        a8 = 8'h35; b8 = 8'h4A; start8 = 1'b1; start4 = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0; start8 = 1'b0; start4 = 1'b0;
        repeat (2) begin @(posedge clk); #1; end

        // Directed carry, wrap and overflow cases.
        applyStimulus(W8, 8'h35, 8'h4A, 1'b0, 1'b0);
        applyStimulus(W8, 8'hFF, 8'h01, 1'b1, 1'b0);
        applyStimulus(W8, 8'h7F, 8'h01, 1'b0, 1'b0);
        applyStimulus(W8, 8'h80, 8'h80, 1'b0, 1'b0);
        applyStimulus(W8, 8'h05, 8'h07, 1'b0, 1'b1);
        applyStimulus(W8, 8'h80, 8'h01, 1'b0, 1'b1);
        applyStimulus(W8, 8'h00, 8'h00, 1'b1, 1'b1);
        applyStimulus(W8, 8'h7F, 8'h80, 1'b1, 1'b1);

        // Continuous start request.
        holdStart(30);

        // Reset arriving while bit 3 is being processed aborts with no done.
        applyStimulus(W8, 8'h12, 8'h34, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(W8, 8'h10, 8'h20, 1'b0, 1'b0);

        // Random operations at WIDTH=8.
        for (int i = 0; i < 150; i++) begin
            applyStimulus(W8, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        end

        // Every operand combination at WIDTH=4.
        for (int s = 0; s < 2; s++) begin
            for (int c = 0; c < 2; c++) begin
                for (int x = 0; x < 16; x++) begin
                    for (int y = 0; y < 16; y++) begin
                        applyStimulus(W4, 8'(x), 8'(y), 1'(c), 1'(s));
                    end
                end
            end
        end

        // Let outstanding results arrive.
        guard = 0;
        while ((q8.size() > 0 || q4.size() > 0) && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (q8.size() > 0 || q4.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d/%0d results outstanding, expected 0", q8.size(), q4.size());
        end
        waitIdle(W8, ok);
        waitIdle(W4, ok);
        repeat (3) begin @(posedge clk); #1; end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
